rtc_save_restore: RTL and testbench
===================================

// Module: rtc_save_restore
// PURPOSE
//  Receive side of the save-file RTC tail. The save handler streams the RTC halfwords that sit
//  past the SRAM image as bk_rtc_wr writes; this block collects them. Once all 5 halfwords
//  (timestamp + saved time) have arrived and the bridge has gone quiet, it presents the two
//  values to the GB RTC core with a single-cycle load strobe. Sits in clk_sys between the
//  save handler and the cart RTC.
// PARAMETERS
//  SETTLE_CYCLES  1024  quiet clk_sys cycles after the last RTC write before commit (>=2)
//  CNT_W          11    settle counter width; must satisfy 2**CNT_W > SETTLE_CYCLES
// PORTS
//  clk_sys           in   1   core clock; the only clock
//  pll_core_locked   in   1   async active-low reset (0 = reset)
//  cart_download     in   1   high while a ROM loads; clears all collected state
//  bk_rtc_wr         in   1   one-cycle write strobe for an RTC halfword
//  bk_addr           in   17  halfword address; bits [7:0] = RTC word index
//  bk_data           in   16  halfword data
//  RTC_timestampIn   out  32  {w1,w0}
//  RTC_savedtimeIn   out  48  {w4,w3,w2}
//  RTC_load          out  1   one-cycle strobe; the outputs are valid in that cycle
//  rtc_restored      out  1   sticky high after a commit, until cart_download or reset
// BEHAVIOUR
//  Reset: all outputs 0, word registers 0, seen mask 0, state IDLE. Reset is async assert,
//   sync release.
//  Word index idx = bk_addr[7:0]. If bk_rtc_wr && idx<=4: reg[idx] <= bk_data and
//   seen[idx] <= 1. idx>=5 writes are ignored; they do not touch the timer or the state.
//  A repeated index overwrites that word; the last write wins.
//  States:
//   IDLE: first accepted write -> COLLECT.
//   COLLECT: stays here until seen==5'h1F. The cycle after the write that completes the mask
//    -> SETTLE, counter cleared.
//   SETTLE: counter increments each cycle with no accepted write. An accepted write clears
//    the counter and stays in SETTLE, so a re-sent image restarts the quiet window. At
//    count==SETTLE_CYCLES-1 -> COMMIT.
//   COMMIT: one cycle. RTC_load=1 and rtc_restored<=1. If RTC_timestampIn==32'hFFFF_FFFF
//    (the value the unloader sends when there is no RTC), suppress RTC_load and
//    rtc_restored. Then -> DONE.
//   DONE: a further accepted write clears seen, stores the word, and goes to COLLECT.
//    This allows a second save load without a ROM reload; rtc_restored stays high.
//  Latency: RTC_load asserts exactly SETTLE_CYCLES+1 cycles after the completing write,
//   provided no later accepted write occurs.
//  RTC_timestampIn / RTC_savedtimeIn are driven from the word registers at all times. They
//   are guaranteed coherent only while RTC_load is high.
//  cart_download high (any state): seen<=0, counter<=0, rtc_restored<=0, state<=IDLE,
//   RTC_load forced 0. Writes are ignored while it is high. cart_download has priority over
//   a simultaneous bk_rtc_wr.
//  Partial tails (fewer than 5 words) never commit; the block stays in COLLECT indefinitely.
//  Counter saturates; it does not wrap.
// STRUCTURE
//  Package gb_rtc_pkg holds:
//   - localparams RTC_WORDS=5, RTC_TS_LO=0 .. RTC_ST_HI=4, RTC_NO_TS=32'hFFFF_FFFF;
//   - typedef enum logic [2:0] rtc_rst_state_t {IDLE,COLLECT,SETTLE,COMMIT,DONE}.
//  The save handler shares the word-index constants so that both ends agree on the layout.
//  One sub-module: quiet_timer (clear, tick, count==N-1 flag, saturating).
//  The FSM and word registers stay in this module.
// TESTING
//  1 Write idx0..4 = 1111,2222,3333,4444,5555 back-to-back, SETTLE_CYCLES=16 ->
//    RTC_load one cycle, exactly 17 cycles after the idx4 write;
//    timestampIn=32'h2222_1111, savedtimeIn=48'h5555_4444_3333; rtc_restored=1.
//  2 Write idx0..3 only, wait 100 cycles -> RTC_load never asserts, rtc_restored=0.
//  3 All 5 words, then rewrite idx2=AAAA at settle count 10 ->
//    commit 17 cycles after the rewrite, with savedtimeIn[15:0]=AAAA.
//  4 All 5 words with w0=w1=FFFF -> no RTC_load, rtc_restored=0, state DONE.
//  5 cart_download pulse during SETTLE, and again after a commit -> no RTC_load,
//    rtc_restored=0. A fresh 5-word set afterwards commits normally.
//  6 Drop pll_core_locked mid-COLLECT -> outputs 0 immediately. After release, idx5/idx200
//    writes change nothing.

Source files
------------

// File: rtl/rtc_save_restore_pkg.sv
// gb_rtc_pkg: RTC save-tail word layout and FSM states, shared with the save handler.
package gb_rtc_pkg;
    localparam int RTC_WORDS = 5;
    localparam int RTC_TS_LO = 0;
    localparam int RTC_TS_HI = 1;
    localparam int RTC_ST_LO = 2;
    localparam int RTC_ST_MID = 3;
    localparam int RTC_ST_HI = 4;
    localparam logic [31:0] RTC_NO_TS = 32'hFFFF_FFFF;
    localparam logic [RTC_WORDS-1:0] RTC_ALL_SEEN = '1;
    typedef enum logic [2:0] {IDLE, COLLECT, SETTLE, COMMIT, DONE} rtc_rst_state_t;
endpackage

// File: rtl/rtc_save_restore_if.sv
// rtc_save_restore_if: save-handler write bus in, cart RTC load bundle out.
interface rtc_save_restore_if;
    logic        cart_download;
    logic        bk_rtc_wr;
    logic [16:0] bk_addr;
    logic [15:0] bk_data;
    logic [31:0] RTC_timestampIn;
    logic [47:0] RTC_savedtimeIn;
    logic        RTC_load;
    logic        rtc_restored;
    modport master (
        output cart_download, bk_rtc_wr, bk_addr, bk_data,
        input  RTC_timestampIn, RTC_savedtimeIn, RTC_load, rtc_restored
    );
    modport slave (
        input  cart_download, bk_rtc_wr, bk_addr, bk_data,
        output RTC_timestampIn, RTC_savedtimeIn, RTC_load, rtc_restored
    );
endinterface

// File: rtl/rtc_save_restore_quiet_timer.sv
// quiet_timer: saturating idle counter; hit_o flags count == N-1.
module quiet_timer #(
    parameter int N = 1024,
    parameter int W = 11
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic tick_i,
    output logic hit_o
);
    localparam logic [W-1:0] LAST = W'(N - 1);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clr_i ? '0 : (tick_i && cnt_q != LAST) ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else cnt_q <= cnt_d;
    assign hit_o = cnt_q == LAST;
endmodule

// File: rtl/rtc_save_restore.sv
// rtc_save_restore: collects the 5 RTC tail halfwords and, after a quiet window,
// pulses them into the cart RTC once.
module rtc_save_restore
    import gb_rtc_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1024,
    parameter int CNT_W = 11
) (
    input logic clk_sys,
    input logic pll_core_locked,
    rtc_save_restore_if.slave bus
);
    logic [1:0] rst_sync_q;
    logic rst_n;
    logic [RTC_WORDS-1:0][15:0] word_q;
    logic [RTC_WORDS-1:0] seen_q, seen_d, onehot;
    rtc_rst_state_t state_q, state_d;
    logic restored_q, restored_d;
    logic [7:0] idx;
    logic acc, hit, load, ts_ok;
    logic [31:0] ts;
    logic unused_addr;

    // Reset asserts asynchronously but releases on a clock edge.
    always_ff @(posedge clk_sys or negedge pll_core_locked)
        if (!pll_core_locked) rst_sync_q <= '0;
        else rst_sync_q <= {rst_sync_q[0], 1'b1};
    assign rst_n = rst_sync_q[1];

    assign idx = bus.bk_addr[7:0];
    assign unused_addr = ^bus.bk_addr[16:8];
    assign acc = bus.bk_rtc_wr && !bus.cart_download && idx < 8'(RTC_WORDS);
    assign onehot = RTC_WORDS'(1) << idx;
    assign ts = {word_q[RTC_TS_HI], word_q[RTC_TS_LO]};
    assign ts_ok = ts != RTC_NO_TS;

    quiet_timer #(.N(SETTLE_CYCLES), .W(CNT_W)) u_timer (
        .clk(clk_sys),
        .rst_n(rst_n),
        .clr_i(bus.cart_download || acc || state_q != SETTLE),
        .tick_i(state_q == SETTLE),
        .hit_o(hit)
    );

    always_comb begin
        seen_d = acc ? seen_q | onehot : seen_q;
        state_d = state_q;
        restored_d = restored_q;
        load = 1'b0;
        case (state_q)
            IDLE, COLLECT: if (acc) state_d = seen_d == RTC_ALL_SEEN ? SETTLE : COLLECT;
            SETTLE: if (!acc && hit) state_d = COMMIT;
            COMMIT: begin
                state_d = DONE;
                load = ts_ok;
                restored_d = restored_q | ts_ok;
            end
            DONE: if (acc) begin
                seen_d = onehot;
                state_d = COLLECT;
            end
            default: state_d = IDLE;
        endcase
        if (bus.cart_download) begin
            seen_d = '0;
            state_d = IDLE;
            restored_d = 1'b0;
            load = 1'b0;
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n)
        if (!rst_n) begin
            word_q <= '0;
            seen_q <= '0;
            state_q <= IDLE;
            restored_q <= 1'b0;
        end else begin
            if (acc) word_q[idx[2:0]] <= bus.bk_data;
            seen_q <= seen_d;
            state_q <= state_d;
            restored_q <= restored_d;
        end

    assign bus.RTC_timestampIn = ts;
    assign bus.RTC_savedtimeIn = {word_q[RTC_ST_HI], word_q[RTC_ST_MID], word_q[RTC_ST_LO]};
    assign bus.RTC_load = load;
    assign bus.rtc_restored = restored_q;
endmodule

// File: tb/tb_rtc_save_restore.sv
// tb_rtc_save_restore: directed bench for the RTC tail collector with SETTLE_CYCLES=16.
module tb_rtc_save_restore;
    import gb_rtc_pkg::*;

    logic clk_sys = 1'b0;
    logic pll_core_locked = 1'b0;
    int errors = 0;
    int checks = 0;
    int first, n;
    logic [31:0] ts;
    logic [47:0] st;

    always #5 clk_sys = ~clk_sys;

    rtc_save_restore_if bus ();

    rtc_save_restore #(.SETTLE_CYCLES(16), .CNT_W(5)) dut (
        .clk_sys(clk_sys),
        .pll_core_locked(pll_core_locked),
        .bus(bus.slave)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [16:0] a, input logic [15:0] d);
        bus.bk_rtc_wr = 1'b1;
        bus.bk_addr = a;
        bus.bk_data = d;
        @(negedge clk_sys);
        bus.bk_rtc_wr = 1'b0;
    endtask

    task automatic wr5(input logic [15:0] a, b, c, d, e);
        wr(17'd0, a);
        wr(17'd1, b);
        wr(17'd2, c);
        wr(17'd3, d);
        wr(17'd4, e);
    endtask

    task automatic cd();
        bus.cart_download = 1'b1;
        @(negedge clk_sys);
        bus.cart_download = 1'b0;
    endtask

    // first = negedges after the call at which RTC_load was first seen, -1 if never.
    task automatic watch(input int cycles, output int f, output int cnt,
                         output logic [31:0] t, output logic [47:0] s);
        f = -1;
        cnt = 0;
        t = '0;
        s = '0;
        for (int i = 1; i <= cycles; i++) begin
            @(negedge clk_sys);
            if (bus.RTC_load === 1'b1) begin
                cnt++;
                if (f < 0) begin
                    f = i;
                    t = bus.RTC_timestampIn;
                    s = bus.RTC_savedtimeIn;
                end
            end
        end
    endtask

    initial begin
        bus.cart_download = 1'b0;
        bus.bk_rtc_wr = 1'b0;
        bus.bk_addr = '0;
        bus.bk_data = '0;
        repeat (3) @(negedge clk_sys);
        chk("rst_load", 64'(bus.RTC_load), 64'd0);
        chk("rst_restored", 64'(bus.rtc_restored), 64'd0);
        chk("rst_ts", 64'(bus.RTC_timestampIn), 64'd0);
        chk("rst_st", 64'(bus.RTC_savedtimeIn), 64'd0);
        chk("rst_state", 64'(dut.state_q), 64'(IDLE));
        pll_core_locked = 1'b1;
        repeat (4) @(negedge clk_sys);

        // 1: full set commits 17 cycles after the idx4 write
        wr5(16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555);
        watch(30, first, n, ts, st);
        chk("t1_latency", 64'(first), 64'd16);
        chk("t1_pulses", 64'(n), 64'd1);
        chk("t1_ts", 64'(ts), 64'h2222_1111);
        chk("t1_st", 64'(st), 64'h5555_4444_3333);
        chk("t1_restored", 64'(bus.rtc_restored), 64'd1);
        chk("t1_state", 64'(dut.state_q), 64'(DONE));
        cd();
        chk("t1_cd_restored", 64'(bus.rtc_restored), 64'd0);

        // 2: partial tail never commits
        wr(17'd0, 16'h1111);
        wr(17'd1, 16'h2222);
        wr(17'd2, 16'h3333);
        wr(17'd3, 16'h4444);
        watch(100, first, n, ts, st);
        chk("t2_pulses", 64'(n), 64'd0);
        chk("t2_restored", 64'(bus.rtc_restored), 64'd0);
        chk("t2_state", 64'(dut.state_q), 64'(COLLECT));
        cd();

        // 3: rewrite at settle count 10 restarts the window
        wr5(16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555);
        repeat (10) @(negedge clk_sys);
        wr(17'd2, 16'hAAAA);
        watch(30, first, n, ts, st);
        chk("t3_latency", 64'(first), 64'd16);
        chk("t3_pulses", 64'(n), 64'd1);
        chk("t3_st_lo", 64'(st[15:0]), 64'hAAAA);
        chk("t3_st", 64'(st), 64'h5555_4444_AAAA);
        cd();

        // 4: no-RTC timestamp suppresses the load
        wr5(16'hFFFF, 16'hFFFF, 16'h3333, 16'h4444, 16'h5555);
        watch(30, first, n, ts, st);
        chk("t4_pulses", 64'(n), 64'd0);
        chk("t4_restored", 64'(bus.rtc_restored), 64'd0);
        chk("t4_state", 64'(dut.state_q), 64'(DONE));
        cd();

        // 5: cart_download in SETTLE and after commit
        wr5(16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555);
        repeat (5) @(negedge clk_sys);
        cd();
        watch(40, first, n, ts, st);
        chk("t5a_pulses", 64'(n), 64'd0);
        chk("t5a_restored", 64'(bus.rtc_restored), 64'd0);
        chk("t5a_state", 64'(dut.state_q), 64'(IDLE));
        wr5(16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555);
        watch(30, first, n, ts, st);
        chk("t5b_pulses", 64'(n), 64'd1);
        chk("t5b_restored", 64'(bus.rtc_restored), 64'd1);
        cd();
        chk("t5c_restored", 64'(bus.rtc_restored), 64'd0);
        chk("t5c_state", 64'(dut.state_q), 64'(IDLE));
        watch(5, first, n, ts, st);
        chk("t5c_pulses", 64'(n), 64'd0);
        wr5(16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505);
        watch(30, first, n, ts, st);
        chk("t5d_latency", 64'(first), 64'd16);
        chk("t5d_ts", 64'(ts), 64'h0202_0101);
        chk("t5d_st", 64'(st), 64'h0505_0404_0303);
        chk("t5d_restored", 64'(bus.rtc_restored), 64'd1);
        cd();

        // 6: async reset mid-COLLECT, then out-of-range indices are ignored
        wr(17'd0, 16'h1234);
        wr(17'd1, 16'h5678);
        wr(17'd2, 16'h9ABC);
        chk("t6_pre_ts", 64'(bus.RTC_timestampIn), 64'h5678_1234);
        chk("t6_pre_state", 64'(dut.state_q), 64'(COLLECT));
        #2 pll_core_locked = 1'b0;
        #1;
        chk("t6_rst_ts", 64'(bus.RTC_timestampIn), 64'd0);
        chk("t6_rst_st", 64'(bus.RTC_savedtimeIn), 64'd0);
        chk("t6_rst_load", 64'(bus.RTC_load), 64'd0);
        chk("t6_rst_restored", 64'(bus.rtc_restored), 64'd0);
        chk("t6_rst_state", 64'(dut.state_q), 64'(IDLE));
        @(negedge clk_sys);
        pll_core_locked = 1'b1;
        repeat (4) @(negedge clk_sys);
        wr(17'd5, 16'hDEAD);
        wr(17'd200, 16'hBEEF);
        watch(30, first, n, ts, st);
        chk("t6_pulses", 64'(n), 64'd0);
        chk("t6_ts", 64'(bus.RTC_timestampIn), 64'd0);
        chk("t6_st", 64'(bus.RTC_savedtimeIn), 64'd0);
        chk("t6_state", 64'(dut.state_q), 64'(IDLE));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
